// File: rtl/twiddle_fetch_sin128_pkg.sv
// twiddle_fetch_pkg: shared widths, constants, quadrant codes and FSM state
// type for the quarter-wave sine ROM twiddle fetcher.
// No ports. Optional feature macro used by the other files:
// TWIDDLE_FETCH_INV_EN.
package twiddle_fetch_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned K_W    = ADDR_W + 2;
  localparam int unsigned Q      = 1 << ADDR_W;
  localparam int unsigned N      = 4 * Q;
  localparam int unsigned CNT_W  = 3;

  // Largest positive ROM word; stands in for S(Q), which the ROM does not hold.
  localparam logic signed [DATA_W-1:0] MAXPOS = {1'b0, {(DATA_W-1){1'b1}}};

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_A,
    ISSUE_B,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/twiddle_fetch_sin128_if.sv
// twiddle_fetch_sin128_if: request channel, ROM read port and twiddle result
// channel of the twiddle fetcher bundled together.
// Signals: req_valid/req_ready/req_k (+req_inv with TWIDDLE_FETCH_INV_EN),
// rom_addr/rom_en/rom_rd_data, tw_valid/tw_ready/tw_re/tw_im.
// Modports: master = fetch controller side, slave = surrounding datapath.
interface twiddle_fetch_sin128_if;
  import twiddle_fetch_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  logic [K_W-1:0]           req_k;
`ifdef TWIDDLE_FETCH_INV_EN
  logic                     req_inv;
`endif
  logic [ADDR_W-1:0]        rom_addr;
  logic                     rom_en;
  logic signed [DATA_W-1:0] rom_rd_data;
  logic                     tw_valid;
  logic                     tw_ready;
  logic signed [DATA_W-1:0] tw_re;
  logic signed [DATA_W-1:0] tw_im;

  modport master (
`ifdef TWIDDLE_FETCH_INV_EN
    input  req_inv,
`endif
    input  req_valid, req_k, rom_rd_data, tw_ready,
    output req_ready, rom_addr, rom_en, tw_valid, tw_re, tw_im
  );

  modport slave (
`ifdef TWIDDLE_FETCH_INV_EN
    output req_inv,
`endif
    output req_valid, req_k, rom_rd_data, tw_ready,
    input  req_ready, rom_addr, rom_en, tw_valid, tw_re, tw_im
  );

endinterface

// File: rtl/twiddle_fetch_sin128_quadrant_map.sv
// twiddle_quadrant_map: combinational quadrant symmetry. Turns the two
// first-quadrant samples A=S(r), B=S(Q-r) into (cos, -sin) of 2*pi*k/N.
// Ports: q (quadrant), a, b (operands in 0..MAXPOS), inv (with
// TWIDDLE_FETCH_INV_EN: return +sin), tw_re (cos), tw_im (-sin or +sin).
module twiddle_quadrant_map
  import twiddle_fetch_pkg::*;
(
  input  logic [1:0]               q,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
`ifdef TWIDDLE_FETCH_INV_EN
  input  logic                     inv,
`endif
  output logic signed [DATA_W-1:0] tw_re,
  output logic signed [DATA_W-1:0] tw_im
);

  logic signed [DATA_W-1:0] sin_v;
  logic signed [DATA_W-1:0] cos_v;

  // Operands are non-negative, so plain negation never overflows.
  always_comb begin
    sin_v = a;
    cos_v = b;
    case (q)
      Q0: begin sin_v = a;  cos_v = b;  end
      Q1: begin sin_v = b;  cos_v = -a; end
      Q2: begin sin_v = -a; cos_v = -b; end
      default: begin sin_v = -b; cos_v = a; end
    endcase
    tw_re = cos_v;
    tw_im = -sin_v;
`ifdef TWIDDLE_FETCH_INV_EN
    if (inv) tw_im = sin_v;
`endif
  end

endmodule

// File: rtl/twiddle_fetch_sin128.sv
// twiddle_fetch_sin128: read-side controller for the 128-entry quarter-wave
// sine ROM. Accepts k (0..511), reads S(r) and S(Q-r), applies quadrant
// symmetry and returns W^k = cos - j*sin over a valid/ready handshake.
// Ports: clk, rst (async, active high), bus (twiddle_fetch_sin128_if.master).
// Parameter ROM_LAT (1..3): ROM address-to-data latency in cycles.
// Optional macro TWIDDLE_FETCH_INV_EN adds req_inv (conjugate result).
module twiddle_fetch_sin128
  import twiddle_fetch_pkg::*;
#(
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  twiddle_fetch_sin128_if.master        bus
);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     accept;
  logic                     load_tw;
  logic                     busy;

  logic [1:0]               q_q;
  logic [ADDR_W-1:0]        r_q;
  logic                     b_sub_q;
  logic                     inv_q;
  logic signed [DATA_W-1:0] a_q, b_q;
  logic signed [DATA_W-1:0] map_re, map_im;

  logic                     req_ready_q, req_ready_d;
  logic                     rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
  logic                     tw_valid_q, tw_valid_d;
  logic signed [DATA_W-1:0] tw_re_q, tw_im_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, cycle counter and next values of the registered outputs.
  // cnt counts cycles from ISSUE_A (0); A data is present at cnt=ROM_LAT,
  // B data at ROM_LAT+1, and the mapped result is registered at ROM_LAT+2.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    load_tw     = 1'b0;
    req_ready_d = 1'b0;
    rom_en_d    = 1'b0;
    rom_addr_d  = '0;
    tw_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req_valid && req_ready_q) begin
          accept  = 1'b1;
          state_d = ISSUE_A;
        end
      end
      ISSUE_A: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ISSUE_B;
      end
      ISSUE_B: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ROM_LAT + 2)) begin
          load_tw = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.tw_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rom_en_d    = (state_d == ISSUE_A) || (state_d == ISSUE_B);
    tw_valid_d  = (state_d == HOLD);
    // Q-r truncated to ADDR_W bits yields 0 for r=0, which is the address wanted.
    if (state_d == ISSUE_A)      rom_addr_d = bus.req_k[ADDR_W-1:0];
    else if (state_d == ISSUE_B) rom_addr_d = ADDR_W'(Q - 32'(r_q));
  end

  assign busy = (state_q == ISSUE_B) || (state_q == WAIT);

  // Request latch, ROM data capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      b_sub_q     <= 1'b0;
      inv_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      req_ready_q <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      tw_valid_q  <= 1'b0;
      tw_re_q     <= '0;
      tw_im_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      tw_valid_q  <= tw_valid_d;
      if (accept) begin
        q_q     <= bus.req_k[K_W-1:ADDR_W];
        r_q     <= bus.req_k[ADDR_W-1:0];
        b_sub_q <= (bus.req_k[ADDR_W-1:0] == '0);
`ifdef TWIDDLE_FETCH_INV_EN
        inv_q   <= bus.req_inv;
`else
        inv_q   <= 1'b0;
`endif
      end
      if (busy && cnt_q == CNT_W'(ROM_LAT))     a_q <= bus.rom_rd_data;
      // S(Q) is not stored; substitute full scale for r=0.
      if (busy && cnt_q == CNT_W'(ROM_LAT + 1)) b_q <= b_sub_q ? MAXPOS : bus.rom_rd_data;
      if (load_tw) begin
        tw_re_q <= map_re;
        tw_im_q <= map_im;
      end
    end
  end

  twiddle_quadrant_map u_map (
    .q     (q_q),
    .a     (a_q),
    .b     (b_q),
`ifdef TWIDDLE_FETCH_INV_EN
    .inv   (inv_q),
`endif
    .tw_re (map_re),
    .tw_im (map_im)
  );

`ifndef TWIDDLE_FETCH_INV_EN
  logic unused_inv;
  assign unused_inv = inv_q;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rom_en    = rom_en_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.tw_valid  = tw_valid_q;
  assign bus.tw_re     = tw_re_q;
  assign bus.tw_im     = tw_im_q;

endmodule

// File: tb/tb_twiddle_fetch_sin128.sv
// Bench for twiddle_fetch_sin128: ROM model with ROM_LAT pipeline, table of
// spec vectors, random sweep against a cos/sin reference, hold and reset
// sequences. Set ROM_LAT to 2 for the longer-latency ROM.
module tb_twiddle_fetch_sin128;
  import twiddle_fetch_pkg::*;

  parameter int unsigned ROM_LAT = 1;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int k;
    bit inv;
    int re;
    int im;
    int hold;
  } vec_t;

  typedef struct {
    int k;
    int re;
    int im;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  twiddle_fetch_sin128_if bus_if ();

  twiddle_fetch_sin128 #(.ROM_LAT(ROM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int addr_log[$];
  int rom_table[Q];
  logic signed [DATA_W-1:0] rom_pipe[ROM_LAT];

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int ref_re(input int k);
    return rnd(32767.0 * $cos(2.0 * PI * k / 512.0));
  endfunction

  function automatic int ref_im(input int k, input bit inv);
    int s;
    s = rnd(32767.0 * $sin(2.0 * PI * k / 512.0));
    return inv ? s : -s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ROM model: data appears ROM_LAT cycles after the address strobe.
  always @(posedge clk) begin
    rom_pipe[0] <= bus_if.rom_en ? DATA_W'(rom_table[bus_if.rom_addr]) : 16'sh5A5A;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    if (bus_if.rom_en) addr_log.push_back(int'(bus_if.rom_addr));
  end
  assign bus_if.rom_rd_data = rom_pipe[ROM_LAT-1];

  // Scoreboard: compare on each completed result handshake.
  always @(negedge clk) begin
    if (!rst && bus_if.tw_valid && bus_if.tw_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("tw_re k=%0d", e.k), int'(bus_if.tw_re), e.re);
        check($sformatf("tw_im k=%0d", e.k), int'(bus_if.tw_im), e.im);
      end
    end
  end

  task automatic wait_ready();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus_if.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_before_req", int'(bus_if.req_ready), 1);
  endtask

  task automatic do_req(input int k, input bit inv, input int hold,
                        input int exp_re, input int exp_im);
    int lat;
    int r;
    logic signed [DATA_W-1:0] re0, im0;
    wait_ready();
    addr_log.delete();
    bus_if.req_valid = 1'b1;
    bus_if.req_k     = K_W'(k);
`ifdef TWIDDLE_FETCH_INV_EN
    bus_if.req_inv   = inv;
`endif
    @(posedge clk);
    sb.push_back('{k: k, re: exp_re, im: exp_im});
    #1;
    bus_if.req_valid = 1'b0;
    check("req_ready_busy", int'(bus_if.req_ready), 0);
    lat = 0;
    while (!bus_if.tw_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency k=%0d", k), lat, ROM_LAT + 3);
    r = k % 128;
    check("rom_reads", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check($sformatf("rom_addr_a k=%0d", k), addr_log[0], r);
      check($sformatf("rom_addr_b k=%0d", k), addr_log[1], (128 - r) % 128);
    end
    re0 = bus_if.tw_re;
    im0 = bus_if.tw_im;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", int'(bus_if.tw_valid), 1);
      check("hold_req_ready", int'(bus_if.req_ready), 0);
      check("hold_re_stable", int'(bus_if.tw_re), int'(re0));
      check("hold_im_stable", int'(bus_if.tw_im), int'(im0));
    end
    bus_if.tw_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.tw_ready = 1'b0;
    check("req_ready_after_ack", int'(bus_if.req_ready), 1);
    check("tw_valid_after_ack", int'(bus_if.tw_valid), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, int'(bus_if.req_ready), 0);
    check({tag, "_tw_valid"}, int'(bus_if.tw_valid), 0);
    check({tag, "_tw_re"}, int'(bus_if.tw_re), 0);
    check({tag, "_tw_im"}, int'(bus_if.tw_im), 0);
    check({tag, "_rom_en"}, int'(bus_if.rom_en), 0);
    check({tag, "_rom_addr"}, int'(bus_if.rom_addr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int seen;
    int k;
    bit inv;

    for (int i = 0; i < int'(Q); i++) rom_table[i] = rnd(32767.0 * $sin(2.0 * PI * i / 512.0));
    bus_if.req_valid = 1'b0;
    bus_if.req_k     = '0;
    bus_if.tw_ready  = 1'b0;
`ifdef TWIDDLE_FETCH_INV_EN
    bus_if.req_inv   = 1'b0;
`endif

    vecs.push_back('{k: 0,   inv: 1'b0, re: 32767,  im: 0,      hold: 0});
    vecs.push_back('{k: 128, inv: 1'b0, re: 0,      im: -32767, hold: 0});
    vecs.push_back('{k: 256, inv: 1'b0, re: -32767, im: 0,      hold: 5});
    vecs.push_back('{k: 384, inv: 1'b0, re: 0,      im: 32767,  hold: 0});
    vecs.push_back('{k: 64,  inv: 1'b0, re: 23170,  im: -23170, hold: 1});
    vecs.push_back('{k: 448, inv: 1'b0, re: 23170,  im: 23170,  hold: 0});
`ifdef TWIDDLE_FETCH_INV_EN
    vecs.push_back('{k: 64,  inv: 1'b1, re: 23170,  im: 23170,  hold: 0});
`endif

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("req_ready_first_cycle", int'(bus_if.req_ready), 1);

    foreach (vecs[i]) do_req(vecs[i].k, vecs[i].inv, vecs[i].hold, vecs[i].re, vecs[i].im);

    // Abort k=64 while waiting on the ROM.
    wait_ready();
    bus_if.req_valid = 1'b1;
    bus_if.req_k     = K_W'(64);
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus_if.tw_valid) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    do_req(128, 1'b0, 0, 0, -32767);

    for (int i = 0; i < 16; i++) begin
      k = int'($urandom_range(0, 511));
`ifdef TWIDDLE_FETCH_INV_EN
      inv = 1'($urandom_range(0, 1));
`else
      inv = 1'b0;
`endif
      do_req(k, inv, int'($urandom_range(0, 2)), ref_re(k), ref_im(k, inv));
    end

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
